// File: rtl/cdc_event_arbiter.sv
// Round-robin scheduler that feeds one shared 4-phase pulse-synchronizer channel from NUM_REQ event sources.
// Define CDC_ARB_TIMEOUT_EN to abort a REQ phase after ACK_TIMEOUT cycles without ack.
module cdc_event_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] evt_i,
  input  logic               xfer_ack_i,
  output logic               xfer_req_o,
  output logic [ID_W-1:0]    xfer_id_o,
  output logic [NUM_REQ-1:0] pend_o,
  output logic [NUM_REQ-1:0] drop_o,
  output logic               busy_o,
  output logic               timeout_o
);

  if (NUM_REQ < 2 || NUM_REQ > 16 || ID_W != $clog2(NUM_REQ) || ACK_TIMEOUT < 1) begin : g_cfg_err
    $error("cdc_event_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACK_LO = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [NUM_REQ-1:0] pend_r;
  logic [NUM_REQ-1:0] drop_r;
  logic [NUM_REQ-1:0] clr_s;
  logic [ID_W-1:0]    rr_r;
  logic [ID_W-1:0]    rr_next_s;
  logic [ID_W-1:0]    id_r;
  logic [ID_W-1:0]    id_next_s;
  logic [ID_W-1:0]    win_s;
  logic               found_s;
  logic               req_r;
  logic               req_next_s;
  logic               busy_r;
  logic               to_r;
  logic               to_pulse_s;
  logic               to_hit_s;
  int                 idx_s;

  // Round-robin winner: first pending bit at or after rr+1, wrapping.
  always_comb begin
    win_s   = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_s = (int'(rr_r) + k) % NUM_REQ;
      if (!found_s && pend_r[ID_W'(idx_s)]) begin
        found_s = 1'b1;
        win_s   = ID_W'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Handshake FSM next-state and next-output logic.
  always_comb begin
    state_next_s = state_r;
    req_next_s   = req_r;
    id_next_s    = id_r;
    rr_next_s    = rr_r;
    clr_s        = '0;
    to_pulse_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A stale high ack blocks grants, which also covers resuming after a mid-handshake reset.
        if (found_s && !xfer_ack_i) begin
          clr_s[win_s] = 1'b1;
          id_next_s    = win_s;
          rr_next_s    = win_s;
          req_next_s   = 1'b1;
          state_next_s = ST_REQ;
        end else begin
          req_next_s   = 1'b0;
        end
      end
      ST_REQ: begin
        if (xfer_ack_i) begin
          req_next_s   = 1'b0;
          state_next_s = ST_ACK_LO;
        end else if (to_hit_s) begin
          req_next_s   = 1'b0;
          to_pulse_s   = 1'b1;
          state_next_s = ST_ACK_LO;
        end else begin
          req_next_s   = 1'b1;
        end
      end
      ST_ACK_LO: begin
        req_next_s = 1'b0;
        if (!xfer_ack_i) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_ACK_LO;
        end
      end
      default: begin
        req_next_s   = 1'b0;
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, pending flags and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      pend_r  <= '0;
      drop_r  <= '0;
      rr_r    <= ID_W'(NUM_REQ - 1);
      id_r    <= '0;
      req_r   <= 1'b0;
      busy_r  <= 1'b0;
      to_r    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      pend_r  <= (pend_r & ~clr_s) | evt_i;
      drop_r  <= evt_i & pend_r & ~clr_s;
      rr_r    <= rr_next_s;
      id_r    <= id_next_s;
      req_r   <= req_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      to_r    <= to_pulse_s;
    end
  end

`ifdef CDC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_r;

  assign to_hit_s = (cnt_r == CNT_W'(ACK_TIMEOUT - 1));

  // Cycles spent in REQ; held at zero elsewhere so every REQ entry starts from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (state_r == ST_REQ) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= '0;
    end
  end
`else
  assign to_hit_s = 1'b0;
`endif

  assign xfer_req_o = req_r;
  assign xfer_id_o  = id_r;
  assign pend_o     = pend_r;
  assign drop_o     = drop_r;
  assign busy_o     = busy_r;
  assign timeout_o  = to_r;

endmodule
